// File: rtl/tour_cmd_if.sv
// Command-processor handshake bundle: command, ready/clear, response and response byte.
interface tour_cmd_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output cmd_rdy,
    output resp,
    input  clr_cmd_rdy,
    input  send_resp
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    input  resp,
    output clr_cmd_rdy,
    output send_resp
  );
endinterface

// File: rtl/tour_cmd.sv
// Plays back a solved knight's tour as vertical-then-horizontal move commands, else passes UART commands.
// Optional feature: define TOUR_FANFARE_EN to request fanfare on every horizontal command.
module tour_cmd #(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        tour_err,
  tour_cmd_if.master  cp
);

  localparam int unsigned IDX_W = 5;
  localparam logic [3:0] OP_MOVE = 4'h2;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] OP_HORZ = 4'h3;
`else
  localparam logic [3:0] OP_HORZ = 4'h2;
`endif
  localparam logic [7:0] HEAD_N    = 8'h00;
  localparam logic [7:0] HEAD_W    = 8'h3F;
  localparam logic [7:0] HEAD_S    = 8'h7F;
  localparam logic [7:0] HEAD_E    = 8'hBF;
  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic             r_tour_err;

  logic [15:0] w_vcmd;
  logic [15:0] w_hcmd;
  logic        w_legal;
  logic        w_last;

  assign w_last   = (r_mv_indx == LAST_IDX);
  assign mv_indx  = r_mv_indx;
  assign tour_err = r_tour_err;

  // One-hot move to (vertical, horizontal) command pair; anything else is illegal.
  always_comb begin
    w_vcmd  = 16'h0000;
    w_hcmd  = 16'h0000;
    w_legal = 1'b1;
    case (move)
      8'h01: begin w_vcmd = {OP_MOVE, HEAD_N, 4'd2}; w_hcmd = {OP_HORZ, HEAD_W, 4'd1}; end
      8'h02: begin w_vcmd = {OP_MOVE, HEAD_N, 4'd2}; w_hcmd = {OP_HORZ, HEAD_E, 4'd1}; end
      8'h04: begin w_vcmd = {OP_MOVE, HEAD_N, 4'd1}; w_hcmd = {OP_HORZ, HEAD_W, 4'd2}; end
      8'h08: begin w_vcmd = {OP_MOVE, HEAD_S, 4'd1}; w_hcmd = {OP_HORZ, HEAD_W, 4'd2}; end
      8'h10: begin w_vcmd = {OP_MOVE, HEAD_S, 4'd2}; w_hcmd = {OP_HORZ, HEAD_W, 4'd1}; end
      8'h20: begin w_vcmd = {OP_MOVE, HEAD_S, 4'd2}; w_hcmd = {OP_HORZ, HEAD_E, 4'd1}; end
      8'h40: begin w_vcmd = {OP_MOVE, HEAD_N, 4'd1}; w_hcmd = {OP_HORZ, HEAD_E, 4'd2}; end
      8'h80: begin w_vcmd = {OP_MOVE, HEAD_S, 4'd1}; w_hcmd = {OP_HORZ, HEAD_E, 4'd2}; end
      default: w_legal = 1'b0;
    endcase
  end

  // Playback sequencer; send_resp alongside clr_cmd_rdy in VERT/HORZ is deliberately dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mv_indx  <= '0;
      r_tour_err <= 1'b0;
    end else begin
      r_tour_err <= 1'b0;
      case (r_state)
        IDLE: if (start_tour) begin
          r_mv_indx <= '0;
          r_state   <= VERT;
        end
        VERT: begin
          if (!w_legal) begin
            r_tour_err <= 1'b1;
            r_state    <= IDLE;
          end else if (cp.clr_cmd_rdy) begin
            r_state <= HOLDV;
          end
        end
        HOLDV: if (cp.send_resp) r_state <= HORZ;
        HORZ:  if (cp.clr_cmd_rdy) r_state <= HOLDH;
        HOLDH: if (cp.send_resp) begin
          if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_mv_indx <= r_mv_indx + IDX_W'(1);
            r_state   <= VERT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command-processor side outputs, combinational from state, index, move and UART inputs.
  always_comb begin
    cp.cmd     = cmd_UART;
    cp.cmd_rdy = cmd_rdy_UART;
    cp.resp    = RESP_BUSY;
    case (r_state)
      IDLE: cp.resp = RESP_IDLE;
      VERT: begin
        cp.cmd     = w_vcmd;
        cp.cmd_rdy = w_legal;
      end
      HOLDV: begin
        cp.cmd     = w_vcmd;
        cp.cmd_rdy = 1'b0;
      end
      HORZ: begin
        cp.cmd     = w_hcmd;
        cp.cmd_rdy = 1'b1;
      end
      HOLDH: begin
        cp.cmd     = w_hcmd;
        cp.cmd_rdy = 1'b0;
        if (w_last) cp.resp = RESP_IDLE;
      end
      default: cp.resp = RESP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: pass-through, move decode sweep, full tour, illegal moves, reset abort.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        tour_err;

  tour_cmd_if ifc();

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .tour_err     (tour_err),
    .cp           (ifc.master)
  );

  always #5 clk = ~clk;

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int rises    = 0;
  logic prev_rdy = 1'b0;

  // Hand-computed vertical commands and horizontal low 12 bits per one-hot bit.
  logic [15:0] vexp [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                            16'h27F2, 16'h27F2, 16'h2001, 16'h27F1};
  logic [11:0] hexp [8] = '{12'h3F1, 12'hBF1, 12'h3F2, 12'h3F2,
                            12'h3F1, 12'hBF1, 12'hBF2, 12'hBF2};

  always @(negedge clk) begin
    if (ifc.cmd_rdy && !prev_rdy) rises++;
    prev_rdy <= ifc.cmd_rdy;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_tour = 1'b0; move = 8'h00; cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0; ifc.clr_cmd_rdy = 1'b0; ifc.send_resp = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
  endtask

  // Full handshake for one knight move; expects to be entered in VERT.
  task automatic do_move(input int idx, input int bitn, input bit last);
    logic [15:0] hc;
    hc = {HOP, hexp[bitn]};
    move = 8'(1 << bitn); #1;
    chk("mv_indx", 16'(mv_indx), 16'(idx));
    chk("vert_cmd", ifc.cmd, vexp[bitn]);
    chk("vert_rdy", 16'(ifc.cmd_rdy), 16'd1);
    chk("vert_resp", 16'(ifc.resp), 16'h5A);
    ifc.clr_cmd_rdy = 1'b1; tick(); ifc.clr_cmd_rdy = 1'b0; #1;
    chk("holdv_rdy", 16'(ifc.cmd_rdy), 16'd0);
    chk("holdv_cmd", ifc.cmd, vexp[bitn]);
    ifc.send_resp = 1'b1; tick(); ifc.send_resp = 1'b0; #1;
    chk("horz_cmd", ifc.cmd, hc);
    chk("horz_rdy", 16'(ifc.cmd_rdy), 16'd1);
    chk("horz_resp", 16'(ifc.resp), 16'h5A);
    ifc.clr_cmd_rdy = 1'b1; tick(); ifc.clr_cmd_rdy = 1'b0; #1;
    chk("holdh_rdy", 16'(ifc.cmd_rdy), 16'd0);
    chk("holdh_cmd", ifc.cmd, hc);
    ifc.send_resp = 1'b1; #1;
    chk("final_resp", 16'(ifc.resp), last ? 16'hA5 : 16'h5A);
    tick(); ifc.send_resp = 1'b0; #1;
  endtask

  initial begin
    do_reset();
    chk("rst_mv_indx", 16'(mv_indx), 16'd0);
    chk("rst_tour_err", 16'(tour_err), 16'd0);
    chk("rst_resp", 16'(ifc.resp), 16'hA5);

    // UART pass-through in IDLE
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; #1;
    chk("pt_cmd", ifc.cmd, 16'h2003);
    chk("pt_rdy", 16'(ifc.cmd_rdy), 16'd1);
    chk("pt_resp", 16'(ifc.resp), 16'hA5);
    cmd_rdy_UART = 1'b0; #1;
    chk("pt_rdy0", 16'(ifc.cmd_rdy), 16'd0);

    // Sweep every one-hot move as the first move of a tour
    for (int b = 0; b < 8; b++) begin
      do_reset();
      move = 8'(1 << b);
      pulse_start();
      do_move(0, b, 1'b0);
      chk("sweep_next_idx", 16'(mv_indx), 16'd1);
    end

    // Full 24-move tour; start_tour mid-tour must be ignored
    do_reset();
    move = 8'h01;
    pulse_start();
    rises = 0;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin
        pulse_start();
        chk("ign_start_idx", 16'(mv_indx), 16'd3);
        chk("ign_start_rdy", 16'(ifc.cmd_rdy), 16'd1);
      end
      do_move(i, i % 8, i == 23);
    end
    chk("tour_rises", 16'(rises), 16'd48);
    chk("end_cmd", ifc.cmd, 16'h1234);
    chk("end_rdy", 16'(ifc.cmd_rdy), 16'd1);
    chk("end_resp", 16'(ifc.resp), 16'hA5);
    chk("end_idx", 16'(mv_indx), 16'd23);

    // Illegal moves at index 5: zero and two bits set
    for (int k = 0; k < 2; k++) begin
      do_reset();
      move = 8'h02;
      pulse_start();
      for (int i = 0; i < 5; i++) do_move(i, 1, 1'b0);
      move = (k == 0) ? 8'h00 : 8'h03; #1;
      chk("ill_idx", 16'(mv_indx), 16'd5);
      chk("ill_rdy", 16'(ifc.cmd_rdy), 16'd0);
      chk("ill_err_pre", 16'(tour_err), 16'd0);
      tick();
      chk("ill_err", 16'(tour_err), 16'd1);
      chk("ill_idle_resp", 16'(ifc.resp), 16'hA5);
      chk("ill_idle_rdy", 16'(ifc.cmd_rdy), 16'd0);
      tick();
      chk("ill_err_clr", 16'(tour_err), 16'd0);
      chk("ill_stay_idle", 16'(ifc.resp), 16'hA5);
    end

    // Asynchronous reset in HOLDH at index 10
    do_reset();
    move = 8'h40;
    pulse_start();
    for (int i = 0; i < 10; i++) do_move(i, 6, 1'b0);
    ifc.clr_cmd_rdy = 1'b1; tick(); ifc.clr_cmd_rdy = 1'b0;
    ifc.send_resp = 1'b1; tick(); ifc.send_resp = 1'b0;
    ifc.clr_cmd_rdy = 1'b1; tick(); ifc.clr_cmd_rdy = 1'b0; #1;
    chk("pre_rst_idx", 16'(mv_indx), 16'd10);
    chk("pre_rst_cmd", ifc.cmd, {HOP, 12'hBF2});
    #2 rst_n = 1'b0; #1;
    chk("async_rst_idx", 16'(mv_indx), 16'd0);
    rst_n = 1'b1;
    cmd_UART = 16'h2003;
    tick();
    chk("post_rst_idx", 16'(mv_indx), 16'd0);
    chk("post_rst_resp", 16'(ifc.resp), 16'hA5);
    chk("post_rst_cmd", ifc.cmd, 16'h2003);
    ifc.send_resp = 1'b1; tick(); ifc.send_resp = 1'b0; tick();
    chk("post_rst_rdy", 16'(ifc.cmd_rdy), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
